// File: rtl/disp_pkg.sv
// Shared types and constants for the display-value controller and its button front end.
package disp_pkg;

   localparam int NUM_W = 8;

   typedef enum logic [2:0] {
      ACT_NONE,
      ACT_CLEAR,
      ACT_LOAD,
      ACT_UP,
      ACT_DOWN
   } action_t;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      REPEAT
   } rep_state_t;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button front end: 2-FF synchroniser, debounced level and a one-cycle press pulse.
module btn_debounce
   import disp_pkg::*;
#(
   parameter int DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic rise
);

   localparam int CNT_W = clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             vld1;
   logic             vld2;
   logic             armed;
   logic [CNT_W-1:0] cnt;

   // A button held through reset stays disarmed until the synchroniser has
   // carried a real sample and that sample reads released.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         vld1  <= 1'b0;
         vld2  <= 1'b0;
         armed <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         vld1  <= 1'b1;
         vld2  <= vld1;
         rise  <= 1'b0;
         if (vld2 && !sync2) armed <= 1'b1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync2;
            rise  <= sync2 & armed;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/disp_value_ctrl.sv
// Turns debounced up/down/load/clear buttons into a saturating display value
// with auto-repeat on held up/down, a sticky overflow flag and an update strobe.
module disp_value_ctrl
   import disp_pkg::*;
#(
   parameter int DB_CYCLES     = 500000,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter int MAX_VAL       = 127
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_load,
   input  logic             btn_clear,
   input  logic [NUM_W-1:0] sw,
   output logic [NUM_W-1:0] num,
   output logic             ovf,
   output logic             upd,
   output rep_state_t       state
);

   localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TMR_W   = clog2(TMR_MAX);
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);
   localparam logic [NUM_W-1:0] MAX_N     = NUM_W'(MAX_VAL);
   localparam logic [NUM_W:0]   MAX_W     = (NUM_W + 1)'(MAX_VAL);

   logic lvl_up, lvl_down, lvl_load, lvl_clear;
   logic p_up, p_down, p_load, p_clear;
   logic unused_lvl;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
      .clk(clk), .rst(rst), .btn(btn_up), .level(lvl_up), .rise(p_up));
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
      .clk(clk), .rst(rst), .btn(btn_down), .level(lvl_down), .rise(p_down));
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
      .clk(clk), .rst(rst), .btn(btn_load), .level(lvl_load), .rise(p_load));
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
      .clk(clk), .rst(rst), .btn(btn_clear), .level(lvl_clear), .rise(p_clear));

   // Only the up/down levels steer auto-repeat.
   assign unused_lvl = lvl_load ^ lvl_clear;

   rep_state_t       state_nxt;
   logic             dir;        // 0 = up, 1 = down
   logic             dir_nxt;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_nxt;
   logic             tick;
   logic             ctrl;
   logic             press;
   logic             dir_lvl;
   action_t          act;
   logic [NUM_W-1:0] num_nxt;
   logic             ovf_nxt;
   logic [NUM_W:0]   num_w;
   logic [NUM_W:0]   sw_w;

   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      timer_nxt = timer;
      tick      = 1'b0;
      ctrl      = p_clear | p_load;
      press     = p_up | p_down;
      dir_lvl   = dir ? lvl_down : lvl_up;
      case (state)
         IDLE: begin
            timer_nxt = '0;
            if (!ctrl && press) begin
               state_nxt = HOLD;
               dir_nxt   = ~p_up;
            end
         end
         default: begin
            // A fresh press (only possible in the other direction) re-arms.
            if (ctrl) begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end else if (press) begin
               state_nxt = HOLD;
               dir_nxt   = ~p_up;
               timer_nxt = '0;
            end else if (!dir_lvl) begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end else if (timer == ((state == HOLD) ? HOLD_LAST : REP_LAST)) begin
               tick      = 1'b1;
               state_nxt = REPEAT;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      act = ACT_NONE;
      if (p_clear)                   act = ACT_CLEAR;
      else if (p_load)               act = ACT_LOAD;
      else if (p_up || (tick && !dir)) act = ACT_UP;
      else if (p_down || (tick && dir)) act = ACT_DOWN;
   end

   always_comb begin
      num_nxt = num;
      ovf_nxt = ovf;
      num_w   = {1'b0, num};
      sw_w    = {1'b0, sw};
      case (act)
         ACT_CLEAR: begin
            num_nxt = '0;
            ovf_nxt = 1'b0;
         end
         ACT_LOAD: begin
            if (sw_w > MAX_W) begin
               num_nxt = MAX_N;
               ovf_nxt = 1'b1;
            end else begin
               num_nxt = sw;
               ovf_nxt = 1'b0;
            end
         end
         ACT_UP: begin
            if (num_w + 1'b1 > MAX_W) begin
               num_nxt = MAX_N;
               ovf_nxt = 1'b1;
            end else begin
               num_nxt = num + 1'b1;
            end
         end
         ACT_DOWN: begin
            if (num == '0) ovf_nxt = 1'b1;
            else           num_nxt = num - 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         dir   <= 1'b0;
         timer <= '0;
         num   <= '0;
         ovf   <= 1'b0;
         upd   <= 1'b0;
      end else begin
         state <= state_nxt;
         dir   <= dir_nxt;
         timer <= timer_nxt;
         num   <= num_nxt;
         ovf   <= ovf_nxt;
         upd   <= (act != ACT_NONE);
      end
   end

endmodule

// File: tb/tb_disp_value_ctrl.sv
// Directed bench for disp_value_ctrl with a reference model feeding an expected-value queue.
module tb_disp_value_ctrl;
   import disp_pkg::*;

   localparam int MAX_VAL = 127;
   localparam logic [3:0] B_UP = 4'b0001, B_DN = 4'b0010, B_LD = 4'b0100, B_CL = 4'b1000;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_up, btn_down, btn_load, btn_clear;
   logic [7:0] sw;
   logic [7:0] num;
   logic       ovf, upd;
   rep_state_t state;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int t0;
   int base;
   logic [8:0] exp_q[$];
   int   m_num;
   logic m_ovf;

   disp_value_ctrl #(
      .DB_CYCLES(4), .HOLD_CYCLES(16), .REPEAT_CYCLES(8), .MAX_VAL(MAX_VAL)
   ) dut (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
      .btn_load(btn_load), .btn_clear(btn_clear), .sw(sw),
      .num(num), .ovf(ovf), .upd(upd), .state(state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model: every applied action pushes the resulting {ovf,num}.
   task automatic push_exp();
      exp_q.push_back({m_ovf, 8'(m_num)});
   endtask
   task automatic m_up();
      if (m_num >= MAX_VAL) m_ovf = 1'b1;
      else m_num++;
      push_exp();
   endtask
   task automatic m_down();
      if (m_num == 0) m_ovf = 1'b1;
      else m_num--;
      push_exp();
   endtask
   task automatic m_load(input int v);
      if (v > MAX_VAL) begin m_num = MAX_VAL; m_ovf = 1'b1; end
      else begin m_num = v; m_ovf = 1'b0; end
      push_exp();
   endtask
   task automatic m_clear();
      m_num = 0; m_ovf = 1'b0;
      push_exp();
   endtask

   // Scoreboard: each upd strobe consumes one expected value.
   always @(posedge clk) begin
      #1;
      if (upd === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL upd_unexpected observed=%0d expected=none", {ovf, num});
         end
         if (exp_q.size() != 0) check("scoreboard", {ovf, num}, exp_q.pop_front());
      end
   end

   task automatic goto_cyc(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
   endtask

   task automatic set_btns(input logic [3:0] m);
      {btn_clear, btn_load, btn_down, btn_up} = m;
   endtask

   // Press for `hold` cycles; the action lands 7 cycles after the raw press.
   task automatic press(input string tag, input logic [3:0] m, input int hold);
      int s;
      s = cyc;
      set_btns(m);
      goto_cyc(s + 7);
      check({tag, "_upd"}, 9'(upd), 9'd1);
      check({tag, "_val"}, {ovf, num}, {m_ovf, 8'(m_num)});
      goto_cyc(s + hold);
      set_btns(4'b0000);
      goto_cyc(s + hold + 12);
   endtask

   initial begin
      rst = 1'b1; sw = 8'd0; set_btns(4'b0000);
      m_num = 0; m_ovf = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("rst_num", 9'(num), 9'd0);
      check("rst_ovf", 9'(ovf), 9'd0);
      check("rst_upd", 9'(upd), 9'd0);
      check("rst_state", 9'(state), 9'(IDLE));
      rst = 1'b0;
      goto_cyc(cyc + 4);

      // 1: press latency, single upd pulse, glitch rejection
      t0 = cyc;
      btn_up = 1'b1;
      m_up();
      goto_cyc(t0 + 6);
      check("t1_before", 9'(num), 9'd0);
      goto_cyc(t0 + 7);
      check("t1_latency", 9'(num), 9'd1);
      check("t1_upd_hi", 9'(upd), 9'd1);
      goto_cyc(t0 + 8);
      check("t1_upd_lo", 9'(upd), 9'd0);
      goto_cyc(t0 + 10);
      btn_up = 1'b0;
      goto_cyc(t0 + 30);
      btn_up = 1'b1;
      goto_cyc(t0 + 33);
      btn_up = 1'b0;
      goto_cyc(t0 + 55);
      check("t1_glitch", 9'(num), 9'd1);

      // 2: auto-repeat, first tick 16 cycles after the step, then every 8
      base = m_num;
      t0 = cyc;
      btn_up = 1'b1;
      repeat (6) m_up();
      goto_cyc(t0 + 22);
      check("t2_pre_tick", 9'(num), 9'(base + 1));
      goto_cyc(t0 + 23);
      check("t2_hold_tick", 9'(num), 9'(base + 2));
      goto_cyc(t0 + 30);
      check("t2_pre_rep", 9'(num), 9'(base + 2));
      goto_cyc(t0 + 31);
      check("t2_rep_tick", 9'(num), 9'(base + 3));
      goto_cyc(t0 + 50);
      check("t2_state_rep", 9'(state), 9'(REPEAT));
      goto_cyc(t0 + 52);
      btn_up = 1'b0;
      goto_cyc(t0 + 60);
      check("t2_state_idle", 9'(state), 9'(IDLE));
      goto_cyc(t0 + 80);
      check("t2_final", 9'(num), 9'(base + 6));

      // 3: oversized load saturates, saturated up still strobes
      sw = 8'd200;
      m_load(200);
      press("t3_load", B_LD, 10);
      m_up();
      press("t3_up_sat", B_UP, 10);

      // 4: clear, underflow, in-range load clears ovf
      m_clear();
      press("t4_clear", B_CL, 10);
      m_down();
      press("t4_down", B_DN, 10);
      sw = 8'd42;
      m_load(42);
      press("t4_load", B_LD, 10);

      // 5: simultaneous up/down/load: load wins, no repeat armed
      sw = 8'd9;
      m_load(9);
      t0 = cyc;
      set_btns(B_UP | B_DN | B_LD);
      goto_cyc(t0 + 7);
      check("t5_val", {ovf, num}, 9'd9);
      goto_cyc(t0 + 8);
      check("t5_state", 9'(state), 9'(IDLE));
      goto_cyc(t0 + 10);
      set_btns(4'b0000);
      goto_cyc(t0 + 40);
      check("t5_final", 9'(num), 9'd9);

      // 6: reset while repeating with the button still held
      sw = 8'd48;
      m_load(48);
      press("t6_load", B_LD, 10);
      t0 = cyc;
      btn_up = 1'b1;
      m_up();
      m_up();
      goto_cyc(t0 + 24);
      check("t6_num50", 9'(num), 9'd50);
      check("t6_state_rep", 9'(state), 9'(REPEAT));
      rst = 1'b1;
      goto_cyc(t0 + 26);
      rst = 1'b0;
      m_num = 0; m_ovf = 1'b0;
      check("t6_q_empty", 9'(exp_q.size()), 9'd0);
      goto_cyc(t0 + 70);
      check("t6_held_num", 9'(num), 9'd0);
      check("t6_held_state", 9'(state), 9'(IDLE));
      btn_up = 1'b0;
      goto_cyc(t0 + 85);
      m_up();
      press("t6_repress", B_UP, 10);
      check("t6_final", 9'(num), 9'd1);

      goto_cyc(cyc + 5);
      check("sb_drain", 9'(exp_q.size()), 9'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
